// File: rtl/seven_segment_scanner.sv
// Multiplexed N-digit seven-segment driver: refresh prescaler, digit scan,
// anti-ghost guard, blink timer, leading-zero suppression, glyph decode.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   digits       flat 4-bit digit values, digit 0 is rightmost
//   dp_in        per-digit decimal point request
//   digit_en     per-digit enable (disabled digits still use their slot)
//   blink_mask   per-digit blink enable
//   lzs_en       leading-zero suppression enable
//   anode        active-low digit anodes
//   segments     active-low {a,b,c,d,e,f,g}
//   dp           active-low decimal point
//   digit_idx    index of the current slot
//   slot_start   one-cycle pulse on the first cycle of each slot
module seven_segment_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int BLINK_DIV    = 25000000,
   parameter int HEX_MODE     = 0,
   localparam int IW = $clog2(NUM_DIGITS > 1 ? NUM_DIGITS : 2)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   input  logic                    lzs_en,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              segments,
   output logic                    dp,
   output logic [IW-1:0]           digit_idx,
   output logic                    slot_start
);

   localparam int RW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam logic [RW-1:0] RMAX  = RW'(REFRESH_DIV - 1);
   localparam logic [RW-1:0] BLANK = RW'(BLANK_CYCLES);
   localparam logic [BW-1:0] BMAX  = BW'(BLINK_DIV - 1);
   localparam logic [IW-1:0] IMAX  = IW'(NUM_DIGITS - 1);

   logic [RW-1:0]         cnt;
   logic [BW-1:0]         bcnt;
   logic                  phase;
   logic [IW-1:0]         idx;

   logic [3:0]            snap_val;
   logic                  snap_dp;
   logic                  snap_en;
   logic                  snap_blk;
   logic                  snap_sup;
   logic                  snap_ph;

   logic [NUM_DIGITS-1:0] sup;
   logic [NUM_DIGITS-1:0] sel;
   logic                  above;
   logic                  zero;

   logic                  first;
   logic [3:0]            cur_val;
   logic                  cur_dp;
   logic                  cur_en;
   logic                  cur_blk;
   logic                  cur_sup;
   logic                  cur_ph;
   logic                  dark;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         default: s = 7'b0111000;
      endcase
      if (HEX_MODE == 0 && v > 4'd9)
         s = 7'h7F;
      return s;
   endfunction

   // Scan from the most significant digit down; a digit is suppressed
   // only while everything above it is also zero.
   always_comb begin
      above = 1'b1;
      zero  = 1'b0;
      sup   = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero   = (digits[4*i +: 4] == 4'd0);
         sup[i] = lzs_en && above && zero && (i != 0);
         above  = above && zero;
      end
   end

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_DIGITS; i++)
         sel[i] = (idx == IW'(i));
   end

   // On the first slot cycle the snapshot registers are still loading,
   // so the live values are used directly.
   assign first   = (cnt == '0);
   assign cur_val = first ? digits[{idx, 2'b00} +: 4] : snap_val;
   assign cur_dp  = first ? dp_in[idx]      : snap_dp;
   assign cur_en  = first ? digit_en[idx]   : snap_en;
   assign cur_blk = first ? blink_mask[idx] : snap_blk;
   assign cur_sup = first ? sup[idx]        : snap_sup;
   assign cur_ph  = first ? phase           : snap_ph;
   assign dark    = !cur_en || (cur_blk && cur_ph) || cur_sup;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         bcnt       <= '0;
         phase      <= 1'b0;
         idx        <= '0;
         snap_val   <= '0;
         snap_dp    <= 1'b0;
         snap_en    <= 1'b0;
         snap_blk   <= 1'b0;
         snap_sup   <= 1'b0;
         snap_ph    <= 1'b0;
         anode      <= '1;
         segments   <= 7'h7F;
         dp         <= 1'b1;
         digit_idx  <= '0;
         slot_start <= 1'b0;
      end else begin
         if (cnt == RMAX) begin
            cnt <= '0;
            idx <= (idx == IMAX) ? '0 : idx + 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end

         if (bcnt == BMAX) begin
            bcnt  <= '0;
            phase <= ~phase;
         end else begin
            bcnt <= bcnt + 1'b1;
         end

         if (first) begin
            snap_val <= cur_val;
            snap_dp  <= cur_dp;
            snap_en  <= cur_en;
            snap_blk <= cur_blk;
            snap_sup <= cur_sup;
            snap_ph  <= cur_ph;
         end

         slot_start <= first;
         digit_idx  <= idx;

         if (cnt < BLANK || dark)
            anode <= '1;
         else
            anode <= ~sel;

         segments <= dark ? 7'h7F : decode(cur_val);
         dp       <= dark ? 1'b1 : ~cur_dp;
      end
   end

endmodule
